sp_ram_arb: RTL
===============

// Module: sp_ram_arb
// PURPOSE
//  Front-end port controller for the single-port RAM. Merges a write-request stream and a
//  read-request stream onto the RAM's one ena/wea/addra/dina port, using round-robin grant.
//  Returns read data on a valid/ready response stream with a 2-entry buffer, so consumer
//  backpressure never loses data despite the RAM's fixed 1-cycle read latency.
// PARAMETERS
//  DATA_WIDTH  32  data bits per word; must match the RAM instance
//  ADDR_WIDTH  10  address bits; must match the RAM instance
// PORTS
//  clk        in   1           single clock; also drives the RAM clka
//  rst_n      in   1           synchronous reset, active-low
//  wr_valid   in   1           write request valid
//  wr_ready   out  1           write request accepted this cycle
//  wr_addr    in   ADDR_WIDTH  write address
//  wr_data    in   DATA_WIDTH  write data
//  rd_valid   in   1           read request valid
//  rd_ready   out  1           read request accepted this cycle
//  rd_addr    in   ADDR_WIDTH  read address
//  rsp_valid  out  1           read response valid
//  rsp_ready  in   1           consumer accepts response
//  rsp_data   out  DATA_WIDTH  read response data, in request order
//  ram_en     out  1           to RAM ena
//  ram_we     out  1           to RAM wea
//  ram_addr   out  ADDR_WIDTH  to RAM addra
//  ram_din    out  DATA_WIDTH  to RAM dina
//  ram_dout   in   DATA_WIDTH  from RAM douta; valid 1 cycle after read issue
// BEHAVIOUR
//  - State: prio (0=write favoured, 1=read favoured), rd_pend (read issued last cycle),
//    cnt (response buffer occupancy, 0..2), 2-entry response FIFO (rd/wr pointers).
//  - Reset (rst_n=0 at posedge): prio=0, rd_pend=0, cnt=0, pointers=0, rsp_valid=0.
//    The reset drops any in-flight read and any buffered responses. RAM contents are untouched.
//    ram_en=0 while rst_n=0, and wr_ready=rd_ready=0 while rst_n=0.
//  - pop = rsp_valid & rsp_ready.
//  - rd_ok = rd_valid & ((cnt + rd_pend - pop) < 2). This read credit covers the in-flight read.
//  - grant_wr = wr_valid & (~rd_ok | prio==0). grant_rd = rd_ok & (~wr_valid | prio==1).
//    At most one grant per cycle.
//  - wr_ready=grant_wr, rd_ready=grant_rd. Both are combinational. They depend on the valids
//    and on rsp_ready, so the upstream must not derive valid from ready.
//  - RAM drive (combinational): ram_en=grant_wr|grant_rd, ram_we=grant_wr,
//    ram_addr=grant_wr?wr_addr:rd_addr, ram_din=wr_data.
//  - prio toggles only when both wr_valid and rd_ok are high and one of them is granted.
//    Otherwise it holds. Under contention the grants alternate W,R,W,R, starting with W
//    after reset.
//  - Read pipeline: grant_rd in cycle T -> rd_pend=1 in T+1 -> ram_dout pushed into the
//    FIFO at the end of T+1 -> rsp_valid=1 in T+2 at the earliest. No bypass path.
//  - cnt_next = cnt + (rd_pend) - pop. The FIFO never overflows (credit rule above).
//    A simultaneous push and pop is legal at any occupancy.
//  - rsp_data = FIFO head. It holds stable while rsp_valid & ~rsp_ready. rsp_valid = (cnt!=0).
//  - Ordering: the RAM port serialises all operations. A read granted after a write to the
//    same address returns the new data; a read granted before it returns the old data.
//  - Throughput: with rsp_ready held at 1, sustains 1 read/cycle, or 1 op/cycle when
//    writes and reads are mixed.
//  - Pointers are 1 bit wide and wrap naturally. Address/data widths pass through unchanged.
// TESTING
//  1 wr addr 3 data 0xA5A50001, then rd addr 3 (rsp_ready=1) -> rsp_valid 2 cyc after
//    rd handshake, rsp_data=0xA5A50001.
//  2 reset, then hold wr_valid=rd_valid=1 for 6 cyc (rsp_ready=1) -> grants W,R,W,R,W,R;
//    ram_we=1,0,1,0,1,0.
//  3 rsp_ready=0, rd_valid=1 to addrs 0..3 (preloaded 0x10..0x13) -> only 2 accepted, then
//    rd_ready=0; raise rsp_ready -> 0x10,0x11 out, then 0x12,0x13 accepted in order.
//  4 rsp_ready=1, 16 back-to-back reads -> rd_ready=1 every cycle; 16 responses on
//    consecutive cycles, in order.
//  5 rd handshake at T, rst_n=0 in T+1 -> rsp_valid=0 from T+2, and no response after the
//    reset is released.
//  6 wr addr 7=0xDEAD and rd addr 7 both valid in the same cycle after reset -> W granted
//    first, rsp_data=0xDEAD.

Source files
------------

// File: rtl/sp_ram_arb.sv
// sp_ram_arb: round-robin merge of write/read request streams onto one single-port RAM port,
// with a 2-entry response buffer that absorbs the RAM's 1-cycle read latency under backpressure.
module sp_ram_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  logic                  prio, rd_pend, wp, rp;
  logic [1:0]            cnt;
  logic [DATA_WIDTH-1:0] fifo [2];
  logic                  pop, rd_ok, grant_wr, grant_rd;
  logic [2:0]            occ;
  // a read is only granted if its response has a guaranteed slot, counting the one in flight
  always_comb begin
    pop      = rsp_valid & rsp_ready;
    occ      = {1'b0, cnt} + {2'b0, rd_pend} - {2'b0, pop};
    rd_ok    = rd_valid & (occ < 3'd2);
    grant_wr = rst_n & wr_valid & (~rd_ok | ~prio);
    grant_rd = rst_n & rd_ok & (~wr_valid | prio);
  end
  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;
  assign ram_en    = grant_wr | grant_rd;
  assign ram_we    = grant_wr;
  assign ram_addr  = grant_wr ? wr_addr : rd_addr;
  assign ram_din   = wr_data;
  assign rsp_valid = cnt != 2'd0;
  assign rsp_data  = fifo[rp];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      rd_pend <= 1'b0;
      cnt     <= 2'd0;
      wp      <= 1'b0;
      rp      <= 1'b0;
    end else begin
      if (wr_valid & rd_ok & (grant_wr | grant_rd)) prio <= ~prio;
      rd_pend <= grant_rd;
      if (rd_pend) begin
        fifo[wp] <= ram_dout;
        wp       <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end
endmodule
